// File: rtl/transpose_fir_bank.sv
// transpose_fir_bank: transposed-form FIR filter, one sample per clock, with
// double-buffered coefficients (shadow bank written by cfg, swapped into the
// active bank by a commit) and valid/busy handshakes on both sample ports.
// Optional feature macro: TPFIR_SAT_EN -- half-up rounding and saturation of
// the output slice; without it the output is a plain two's-complement slice.
module transpose_fir_bank #(
  parameter int DWIDTH = 8,
  parameter int TAPS   = 16,
  parameter int AWIDTH = 4,
  parameter int OWIDTH = 16,
  parameter int OSTART = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_busy,
  input  logic [AWIDTH-1:0] cfg_addr,
  input  logic [DWIDTH-1:0] cfg_data,
  input  logic              cfg_commit,
  input  logic              fir_flush,
  input  logic              fir_din_valid,
  output logic              fir_din_busy,
  input  logic [DWIDTH-1:0] fir_din_data,
  output logic              fir_dout_valid,
  input  logic              fir_dout_busy,
  output logic [OWIDTH-1:0] fir_dout_data
);

  localparam int ACCW = 2 * DWIDTH + $clog2(TAPS);
  localparam logic [AWIDTH:0] TAPS_LIM = (AWIDTH + 1)'(TAPS);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } commit_state_t;

  commit_state_t state;
  commit_state_t state_next;

  logic signed [DWIDTH-1:0] shadow [TAPS];
  logic signed [DWIDTH-1:0] active [TAPS];
  logic signed [ACCW-1:0]   z      [1:TAPS-1];
  logic signed [ACCW-1:0]   prod   [TAPS];
  logic signed [ACCW-1:0]   acc_next;
  logic        [OWIDTH-1:0] dout_next;
  logic                     accept;
  logic                     cfg_write;

  // A held output or a flush blocks the input; flush wins over a new sample.
  assign fir_din_busy = fir_flush || (fir_dout_valid && fir_dout_busy);
  assign accept       = fir_din_valid && !fir_din_busy;
  assign cfg_busy     = (state == ST_PEND);
  assign cfg_write    = cfg_valid && !cfg_busy && ({1'b0, cfg_addr} < TAPS_LIM);

  // Commit FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Commit FSM next state: one PEND cycle, during which the swap happens.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (cfg_commit) begin
          state_next = ST_PEND;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_PEND: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Coefficient banks: cfg writes fill shadow; leaving PEND copies shadow to active.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) begin
        shadow[k] <= '0;
        active[k] <= '0;
      end
    end else begin
      if (cfg_write) begin
        shadow[cfg_addr] <= cfg_data;
      end
      if (state == ST_PEND) begin
        for (int k = 0; k < TAPS; k++) begin
          active[k] <= shadow[k];
        end
      end
    end
  end

  // Full-precision tap products, sign-extended to the accumulator width.
  always_comb begin
    for (int k = 0; k < TAPS; k++) begin
      prod[k] = ACCW'(active[k]) * ACCW'($signed(fir_din_data));
    end
    acc_next = prod[0] + z[1];
  end

`ifdef TPFIR_SAT_EN
  localparam int RSH = (OSTART > 0) ? OSTART - 1 : 0;
  localparam logic signed [ACCW:0] RND  = (OSTART > 0) ? ((ACCW + 1)'(1'b1) << RSH) : '0;
  localparam logic signed [ACCW:0] OMAX = (ACCW + 1)'((64'sd1 <<< (OWIDTH - 1)) - 64'sd1);
  localparam logic signed [ACCW:0] OMIN = (ACCW + 1)'(-(64'sd1 <<< (OWIDTH - 1)));

  logic signed [ACCW:0] acc_wide;
  logic signed [ACCW:0] acc_shift;

  // Round half-up on the dropped LSBs, then clamp to the signed output range.
  always_comb begin
    acc_wide  = {acc_next[ACCW-1], acc_next};
    acc_wide  = acc_wide + RND;
    acc_shift = acc_wide >>> OSTART;
    if (acc_shift > OMAX) begin
      dout_next = OWIDTH'(OMAX);
    end else if (acc_shift < OMIN) begin
      dout_next = OWIDTH'(OMIN);
    end else begin
      dout_next = OWIDTH'(acc_shift);
    end
  end
`else
  // Plain slice acc[OSTART+OWIDTH-1:OSTART], wrapping on overflow.
  always_comb begin
    dout_next = OWIDTH'(acc_next >>> OSTART);
  end
`endif

  // Delay line and output register; state moves only on an accepted sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k < TAPS; k++) begin
        z[k] <= '0;
      end
      fir_dout_valid <= 1'b0;
      fir_dout_data  <= '0;
    end else if (fir_flush) begin
      for (int k = 1; k < TAPS; k++) begin
        z[k] <= '0;
      end
      fir_dout_valid <= 1'b0;
      fir_dout_data  <= '0;
    end else if (accept) begin
      for (int k = 1; k < TAPS - 1; k++) begin
        z[k] <= z[k+1] + prod[k];
      end
      z[TAPS-1]      <= prod[TAPS-1];
      fir_dout_valid <= 1'b1;
      fir_dout_data  <= dout_next;
    end else if (fir_dout_valid && !fir_dout_busy) begin
      fir_dout_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_transpose_fir_bank.sv
// tb_transpose_fir_bank: table-driven and randomized bench for transpose_fir_bank.
// The reference model keeps the last TAPS accepted samples together with the
// coefficient bank that was active when each was accepted, and forms the output
// as a direct convolution sum.
module tb_transpose_fir_bank;

  localparam int DW = 8;
  localparam int TP = 12;
  localparam int AW = 4;
  localparam int OW = 16;
  localparam int OS = 0;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_valid, cfg_busy, cfg_commit, fir_flush;
  logic [AW-1:0] cfg_addr;
  logic [DW-1:0] cfg_data, fir_din_data;
  logic          fir_din_valid, fir_din_busy, fir_dout_valid, fir_dout_busy;
  logic [OW-1:0] fir_dout_data;

  transpose_fir_bank #(.DWIDTH(DW), .TAPS(TP), .AWIDTH(AW), .OWIDTH(OW), .OSTART(OS)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_busy(cfg_busy), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_commit(cfg_commit), .fir_flush(fir_flush),
    .fir_din_valid(fir_din_valid), .fir_din_busy(fir_din_busy), .fir_din_data(fir_din_data),
    .fir_dout_valid(fir_dout_valid), .fir_dout_busy(fir_dout_busy), .fir_dout_data(fir_dout_data)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int            m_act [TP];
  int            m_sh  [TP];
  logic          m_pend;
  int            hist_x [TP];
  int            hist_h [TP][TP];
  logic [OW-1:0] exp_q [$];

  typedef struct {
    logic          dv;
    logic [DW-1:0] dd;
    logic          ob;
    logic          ev;
    logic [OW-1:0] ed;
  } vec_t;
  vec_t tbl [16];

  logic          ov;
  logic [OW-1:0] od;

  task automatic check(input string name, input longint got, input longint want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic logic [OW-1:0] shape(input longint acc);
    longint s;
`ifdef TPFIR_SAT_EN
    longint maxv, minv, rnd;
    maxv = (longint'(1) <<< (OW - 1)) - 1;
    minv = -(longint'(1) <<< (OW - 1));
    rnd  = (OS > 0) ? (longint'(1) <<< ((OS > 0) ? OS - 1 : 0)) : 0;
    s = (acc + rnd) >>> OS;
    if (s > maxv) s = maxv;
    else if (s < minv) s = minv;
`else
    s = acc >>> OS;
`endif
    return s[OW-1:0];
  endfunction

  task automatic model_clear_line();
    for (int i = 0; i < TP; i++) begin
      hist_x[i] = 0;
      for (int k = 0; k < TP; k++) hist_h[i][k] = 0;
    end
  endtask

  task automatic model_reset();
    model_clear_line();
    for (int k = 0; k < TP; k++) begin
      m_act[k] = 0;
      m_sh[k]  = 0;
    end
    m_pend = 1'b0;
    exp_q.delete();
  endtask

  // One clock: drive inputs, check outputs against the model, advance the model.
  task automatic cycle(input logic dv, input logic [DW-1:0] dd, input logic ob, input logic fl,
                       input logic cv, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                       input logic cc, output logic o_v, output logic [OW-1:0] o_d);
    logic   exp_busy, acc;
    longint y;
    @(negedge clk);
    fir_din_valid = dv; fir_din_data = dd; fir_dout_busy = ob; fir_flush = fl;
    cfg_valid = cv; cfg_addr = ca; cfg_data = cd; cfg_commit = cc;
    #1;
    o_v = fir_dout_valid;
    o_d = fir_dout_data;
    check("dout_valid", o_v, exp_q.size() != 0);
    if (exp_q.size() != 0) check("dout_data", o_d, exp_q[0]);
    exp_busy = fl || ((exp_q.size() != 0) && ob);
    check("din_busy", fir_din_busy, exp_busy);
    check("cfg_busy", cfg_busy, m_pend);
    acc = dv && !exp_busy;
    if (fl) begin
      model_clear_line();
      exp_q.delete();
    end else begin
      if (exp_q.size() != 0 && !ob) void'(exp_q.pop_front());
      if (acc) begin
        for (int i = TP - 1; i > 0; i--) begin
          hist_x[i] = hist_x[i-1];
          for (int k = 0; k < TP; k++) hist_h[i][k] = hist_h[i-1][k];
        end
        hist_x[0] = int'($signed(dd));
        for (int k = 0; k < TP; k++) hist_h[0][k] = m_act[k];
        y = 0;
        for (int i = 0; i < TP; i++) y += longint'(hist_h[i][i]) * hist_x[i];
        exp_q.push_back(shape(y));
      end
    end
    if (m_pend) begin
      for (int k = 0; k < TP; k++) m_act[k] = m_sh[k];
      m_pend = 1'b0;
    end else begin
      if (cv && int'(ca) < TP) m_sh[ca] = int'($signed(cd));
      if (cc) m_pend = 1'b1;
    end
  endtask

  task automatic stream(input int n, input logic [DW-1:0] x);
    for (int i = 0; i < n; i++) cycle(1'b1, x, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, ov, od);
  endtask

  // mode 0: h[k]=k+1, mode 1: h[k]=127, mode 2: h[k]=-(k+1)
  task automatic load_bank(input int mode, input logic dv, input logic [DW-1:0] x);
    logic [DW-1:0] c;
    for (int i = 0; i < 2; i++) cycle(dv, x, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, ov, od);
    for (int k = 0; k < TP; k++) begin
      c = (mode == 0) ? DW'(k + 1) : (mode == 1) ? 8'd127 : DW'(-(k + 1));
      cycle(dv, x, 1'b0, 1'b0, 1'b1, AW'(k), c, 1'b0, ov, od);
    end
    cycle(dv, x, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, ov, od);
    cycle(dv, x, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, ov, od);
  endtask

  task automatic random_run(input int n);
    for (int i = 0; i < n; i++)
      cycle($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 1) == 1,
            $urandom_range(0, 39) == 0, $urandom_range(0, 5) == 0, AW'($urandom),
            DW'($urandom), $urandom_range(0, 24) == 0, ov, od);
  endtask

  initial begin
    longint sat_exp;
    // impulse table with a one-cycle stall at entry 5
    for (int i = 0; i < 16; i++) begin
      tbl[i].dv = 1'b1;
      tbl[i].dd = (i == 0) ? 8'd1 : 8'd0;
      tbl[i].ob = (i == 5);
      tbl[i].ev = (i != 0);
      if (i == 0) tbl[i].ed = 16'd0;
      else if (i <= 5) tbl[i].ed = OW'(i);
      else tbl[i].ed = (i - 2 < TP) ? OW'(i - 1) : 16'd0;
    end

    rst_n = 1'b0;
    cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_commit = 1'b0; fir_flush = 1'b0;
    fir_din_valid = 1'b0; fir_din_data = '0; fir_dout_busy = 1'b0;
    model_reset();
    #2;
    check("rst_dout_valid", fir_dout_valid, 0);
    check("rst_dout_data", fir_dout_data, 0);
    check("rst_din_busy", fir_din_busy, 0);
    check("rst_cfg_busy", cfg_busy, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // impulse response with h[k]=k+1
    load_bank(0, 1'b0, 8'd0);
    for (int i = 0; i < 16; i++) begin
      cycle(tbl[i].dv, tbl[i].dd, tbl[i].ob, 1'b0, 1'b0, '0, '0, 1'b0, ov, od);
      check("imp_valid", ov, tbl[i].ev);
      if (tbl[i].ev) check("imp_data", od, tbl[i].ed);
    end

    // full-range: h=127, x=-128 sustained
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, '0, '0, 1'b0, ov, od);
    load_bank(1, 1'b0, 8'd0);
    stream(20, 8'h80);
`ifdef TPFIR_SAT_EN
    sat_exp = 32768;
`else
    sat_exp = 1536;
`endif
    check("fullrange", od, sat_exp);

    // mid-stream commit to h'=-h
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, '0, '0, 1'b0, ov, od);
    load_bank(0, 1'b0, 8'd0);
    stream(14, 8'd1);
    check("old_bank_steady", od, 78);
    load_bank(2, 1'b1, 8'd1);
    stream(14, 8'd1);
    check("new_bank_steady", od, 65458);

    // flush during stream, then ignored out-of-range cfg writes
    cycle(1'b1, 8'd1, 1'b0, 1'b1, 1'b0, '0, '0, 1'b0, ov, od);
    check("flush_refuse", fir_din_busy, 1);
    stream(1, 8'd1);
    stream(1, 8'd0);
    check("post_flush_0", od, 65535);
    stream(1, 8'd0);
    check("post_flush_1", od, 65534);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 4'd12, 8'h55, 1'b0, ov, od);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 4'd15, 8'h33, 1'b0, ov, od);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 4'd13, 8'h11, 1'b1, ov, od);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, '0, '0, 1'b0, ov, od);
    stream(1, 8'd1);
    stream(1, 8'd0);
    check("oob_write_ignored", od, 65535);

    // random traffic with backpressure, cfg writes, commits and flushes
    random_run(300);

    // reset mid-stream
    cycle(1'b1, 8'd5, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, ov, od);
    #2;
    cfg_valid = 1'b0; cfg_commit = 1'b0; fir_flush = 1'b0;
    fir_din_valid = 1'b0; fir_dout_busy = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_dout_valid", fir_dout_valid, 0);
    check("midrst_cfg_busy", cfg_busy, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    stream(1, 8'd1);
    stream(1, 8'd0);
    check("rst_imp_valid", ov, 1);
    check("rst_imp_zero", od, 0);

    random_run(300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
